// File: rtl/denormalizacion.sv
// Re-aligns a normalized mantissa/exponent pair to a target exponent, one bit per
// falling edge of clkDenorm; right shifts raise the exponent, left shifts lower it.
module denormalizacion #(
  parameter int SIZE  = 10,
  parameter int EXP_W = 5
) (
  input  logic             clkDenorm,
  input  logic             rstDenorm_n,
  input  logic             start,
  input  logic [SIZE-1:0]  vect,
  input  logic [EXP_W-1:0] exp,
  input  logic [EXP_W-1:0] expTarget,
  output logic             busy,
  output logic             done,
  output logic [SIZE-1:0]  mantOut,
  output logic [EXP_W-1:0] expOut,
  output logic             sticky,
  output logic             ovf
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [SIZE-1:0]  m, mnext;
  logic [EXP_W-1:0] e, enext, t;
  logic             stickyacc, snext, ovfacc, onext;

  // One alignment step toward the target; bits pushed out are folded into the flags
  always_comb begin
    mnext = m;
    enext = e;
    snext = stickyacc;
    onext = ovfacc;
    if (e < t) begin
      mnext = m >> 1;
      snext = stickyacc | m[0];
      enext = e + EXP_W'(1);
    end else if (e > t) begin
      mnext = m << 1;
      onext = ovfacc | m[SIZE-1];
      enext = e - EXP_W'(1);
    end
  end

  always_ff @(negedge clkDenorm or negedge rstDenorm_n) begin
    if (!rstDenorm_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mantOut   <= '0;
      expOut    <= '0;
      sticky    <= 1'b0;
      ovf       <= 1'b0;
      m         <= '0;
      e         <= '0;
      t         <= '0;
      stickyacc <= 1'b0;
      ovfacc    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m         <= vect;
            e         <= exp;
            t         <= expTarget;
            stickyacc <= 1'b0;
            ovfacc    <= 1'b0;
            // Already aligned: result is ready on the capture edge itself
            if (exp == expTarget) begin
              done    <= 1'b1;
              mantOut <= vect;
              expOut  <= exp;
              sticky  <= 1'b0;
              ovf     <= 1'b0;
            end else begin
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          m         <= mnext;
          e         <= enext;
          stickyacc <= snext;
          ovfacc    <= onext;
          if (enext == t) begin
            mantOut <= mnext;
            expOut  <= enext;
            sticky  <= snext;
            ovf     <= onext;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
